// File: rtl/svi_force_sched.sv
// Force/release sequencer for one shared W-bit net among N requesters.
// Round-robin grant in IDLE, timed or release-terminated hold in FORCE, one-cycle RELEASE.
module svi_force_sched #(
    parameter int N  = 4,
    parameter int W  = 1,
    parameter int LW = 8
) (
    input  logic            i_sclk,
    input  logic            i_srst,
    input  logic [N-1:0]    i_req,
    input  logic [N*W-1:0]  i_req_val,
    input  logic [N*LW-1:0] i_req_len,
    input  logic [N-1:0]    i_rel,
    input  logic [W-1:0]    i_drv,
    output logic [W-1:0]    o_net,
    output logic [N-1:0]    o_gnt,
    output logic            o_forced,
    output logic            o_done
);

    localparam int PW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_FORCE   = 2'd1,
        S_RELEASE = 2'd2
    } state_t;

    state_t          state_q;
    state_t          state_d;
    logic [PW-1:0]   ptr_q;
    logic [PW-1:0]   own_q;
    logic [W-1:0]    val_q;
    logic [LW-1:0]   cnt_q;
    logic            timed_q;

    logic [PW-1:0]   pick;
    logic            pick_vld;
    logic [W-1:0]    sel_val;
    logic [LW-1:0]   sel_len;
    logic            own_rel;
    logic            expire;

    // First requester at or after ptr, wrapping around.
    always_comb begin
        pick     = '0;
        pick_vld = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (!pick_vld && i_req[(int'(ptr_q) + i) % N]) begin
                pick_vld = 1'b1;
                pick     = PW'((int'(ptr_q) + i) % N);
            end
        end
    end

    assign sel_val = i_req_val[int'(pick)*W +: W];
    assign sel_len = i_req_len[int'(pick)*LW +: LW];
    assign own_rel = i_rel[own_q];
    assign expire  = timed_q && (cnt_q == LW'(1));

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:    if (pick_vld) state_d = S_FORCE;
            S_FORCE:   if (own_rel || expire) state_d = S_RELEASE;
            S_RELEASE: state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_sclk) begin
        if (i_srst) begin
            state_q <= S_IDLE;
            ptr_q   <= '0;
            own_q   <= '0;
            val_q   <= '0;
            cnt_q   <= '0;
            timed_q <= 1'b0;
        end else begin
            state_q <= state_d;
            case (state_q)
                S_IDLE: begin
                    if (pick_vld) begin
                        own_q   <= pick;
                        val_q   <= sel_val;
                        cnt_q   <= sel_len;
                        timed_q <= (sel_len != '0);
                    end
                end
                S_FORCE: begin
                    if (cnt_q != '0) cnt_q <= cnt_q - LW'(1);
                    // Pointer moves past the owner as the force ends.
                    if (state_d == S_RELEASE) begin
                        ptr_q <= (own_q == PW'(N-1)) ? '0 : own_q + PW'(1);
                        cnt_q <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_forced = (state_q == S_FORCE);
    assign o_done   = (state_q == S_RELEASE);
    assign o_gnt    = o_forced ? (N'(1) << own_q) : '0;
    assign o_net    = o_forced ? val_q : i_drv;

endmodule

// File: tb/tb_svi_force_sched.sv
// Directed bench for svi_force_sched: per-cycle expected outputs are queued by the
// driver and compared by an independent negedge monitor.
module tb_svi_force_sched;

  logic        clk;
  logic        rst;
  logic [3:0]  req;
  logic [31:0] req_val;
  logic [31:0] req_len;
  logic [3:0]  rel;
  logic [7:0]  drv;
  logic [7:0]  net;
  logic [3:0]  gnt;
  logic        forced;
  logic        done;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // {net[7:0], gnt[3:0], forced, done}
  logic [13:0] exp_q[$];

  svi_force_sched #(.N(4), .W(8), .LW(8)) dut (
    .i_sclk    (clk),
    .i_srst    (rst),
    .i_req     (req),
    .i_req_val (req_val),
    .i_req_len (req_len),
    .i_rel     (rel),
    .i_drv     (drv),
    .o_net     (net),
    .o_gnt     (gnt),
    .o_forced  (forced),
    .o_done    (done)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // scoreboard compare
  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  // monitor
  always @(negedge clk) begin
    logic [13:0] e;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      chk("net", net, e[13:6]);
      chk("gnt", {4'b0, gnt}, {4'b0, e[5:2]});
      chk("forced", {7'b0, forced}, {7'b0, e[1]});
      chk("done", {7'b0, done}, {7'b0, e[0]});
    end
  end

  // driver tasks
  task automatic set_req(input int k, input logic [7:0] val, input logic [7:0] len);
    req_val[k*8 +: 8] = val;
    req_len[k*8 +: 8] = len;
  endtask

  task automatic step(input logic [7:0] e_net, input logic [3:0] e_gnt,
                      input logic e_f, input logic e_d);
    exp_q.push_back({e_net, e_gnt, e_f, e_d});
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; req = '0; req_val = '0; req_len = '0; rel = '0; drv = 8'h00;
    repeat (2) @(posedge clk);
    #1;

    // reset state and idle passthrough
    drv = 8'h11;
    step(8'h11, 4'h0, 0, 0);
    rst = 1'b0;
    repeat (3) step(8'h11, 4'h0, 0, 0);

    // round robin 0,1,3,0 with len=1, requests held
    set_req(0, 8'h10, 8'd1); set_req(1, 8'h20, 8'd1); set_req(3, 8'h30, 8'd1);
    req = 4'b1011;
    step(8'h11, 4'h0, 0, 0);
    step(8'h10, 4'h1, 1, 0);
    step(8'h11, 4'h0, 0, 1);
    step(8'h11, 4'h0, 0, 0);
    step(8'h20, 4'h2, 1, 0);
    step(8'h11, 4'h0, 0, 1);
    step(8'h11, 4'h0, 0, 0);
    step(8'h30, 4'h8, 1, 0);
    step(8'h11, 4'h0, 0, 1);
    step(8'h11, 4'h0, 0, 0);
    req = 4'b0000;
    step(8'h10, 4'h1, 1, 0);
    step(8'h11, 4'h0, 0, 1);
    step(8'h11, 4'h0, 0, 0);

    // timed hold of 3 cycles; value and driver changes ignored while forced
    set_req(2, 8'hA5, 8'd3);
    req = 4'b0100;
    step(8'h11, 4'h0, 0, 0);
    req = 4'b0000;
    step(8'hA5, 4'h4, 1, 0);
    set_req(2, 8'h5A, 8'd3);
    drv = 8'h77;
    step(8'hA5, 4'h4, 1, 0);
    step(8'hA5, 4'h4, 1, 0);
    drv = 8'h22;
    step(8'h22, 4'h0, 0, 1);
    step(8'h22, 4'h0, 0, 0);

    // untimed hold: non-owner release ignored, owner release ends it
    set_req(1, 8'h3C, 8'd0);
    req = 4'b0010;
    step(8'h22, 4'h0, 0, 0);
    step(8'h3C, 4'h2, 1, 0);
    rel = 4'b0001;
    step(8'h3C, 4'h2, 1, 0);
    rel = 4'b0000;
    req = 4'b0000;
    step(8'h3C, 4'h2, 1, 0);
    step(8'h3C, 4'h2, 1, 0);
    rel = 4'b0010;
    step(8'h3C, 4'h2, 1, 0);
    rel = 4'b0000;
    step(8'h22, 4'h0, 0, 1);
    step(8'h22, 4'h0, 0, 0);

    // reset mid-force: no done pulse, pointer back to requester 0
    set_req(2, 8'h99, 8'd4);
    req = 4'b0100;
    step(8'h22, 4'h0, 0, 0);
    req = 4'b0000;
    step(8'h99, 4'h4, 1, 0);
    step(8'h99, 4'h4, 1, 0);
    rst = 1'b1;
    step(8'h99, 4'h4, 1, 0);
    rst = 1'b0;
    set_req(0, 8'h44, 8'd2);
    req = 4'b0101;
    step(8'h22, 4'h0, 0, 0);
    req = 4'b0000;
    step(8'h44, 4'h1, 1, 0);
    step(8'h44, 4'h1, 1, 0);
    step(8'h22, 4'h0, 0, 1);
    step(8'h22, 4'h0, 0, 0);

    // maximum finite hold length 255
    set_req(3, 8'hEE, 8'd255);
    req = 4'b1000;
    step(8'h22, 4'h0, 0, 0);
    req = 4'b0000;
    for (int i = 0; i < 255; i++) step(8'hEE, 4'h8, 1, 0);
    step(8'h22, 4'h0, 0, 1);
    step(8'h22, 4'h0, 0, 0);

    @(negedge clk);
    #1;
    chk("queue_drained", 8'(exp_q.size()), 8'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
